// File: rtl/aibfifo_param.sv
// aibfifo_param: parametrised dual-clock FIFO with gray-coded pointer crossing,
// registered full/empty/almost flags, fill counts in both domains and sticky
// overflow/underflow flags. Write side runs on WCLOCK, read side on RCLOCK.
//
// Handshake: a write is taken on a WCLOCK edge when WE=1 and FULL=0; a read is
// taken on an RCLOCK edge when RE=1 and EMPTY=0, and its data is presented on
// RDATA with RDVAL=1 for the following cycle. Requests made against an
// asserted FULL/EMPTY are dropped and recorded in WOVF/RUDF.
module aibfifo_param #(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 6,
    parameter int AFULL_TH    = 56,
    parameter int AEMPTY_TH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              RCLOCK,
    input  logic              RESET_R,
    input  logic              WCLOCK,
    input  logic              RESET_W,
    input  logic [DWIDTH-1:0] WDATA,
    input  logic              WE,
    input  logic              RE,
    output logic [DWIDTH-1:0] RDATA,
    output logic              RDVAL,
    output logic              FULL,
    output logic              AFULL,
    output logic [AWIDTH:0]   WCOUNT,
    output logic              WOVF,
    output logic              EMPTY,
    output logic              AEMPTY,
    output logic [AWIDTH:0]   RCOUNT,
    output logic              RUDF
);

    localparam int              DEPTH      = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_LVL  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_LVL  = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] AEMPTY_LVL = (AWIDTH+1)'(AEMPTY_TH);

    function automatic logic [AWIDTH:0] bin2gray(input logic [AWIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
        logic [AWIDTH:0] b;
        b[AWIDTH] = g[AWIDTH];
        for (int i = AWIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Storage: inferred simple dual-port RAM, no reset.
    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic                               w_ok;
    logic [AWIDTH:0]                    wptr;
    logic [AWIDTH:0]                    wptr_next;
    logic [AWIDTH:0]                    wgray;
    logic [AWIDTH:0]                    rptr_sync;
    logic [AWIDTH:0]                    wcount_next;
    logic [SYNC_STAGES-1:0][AWIDTH:0]   rgray_sync;

    // Read-side gray pointer as seen from the write domain.
    logic [AWIDTH:0] rgray;

    assign w_ok        = WE & ~FULL;
    assign wptr_next   = wptr + {{AWIDTH{1'b0}}, w_ok};
    assign rptr_sync   = gray2bin(rgray_sync[SYNC_STAGES-1]);
    assign wcount_next = wptr_next - rptr_sync;

    // Write RAM port: only accepted words reach the array.
    always_ff @(posedge WCLOCK) begin
        if (w_ok) begin
            mem[wptr[AWIDTH-1:0]] <= WDATA;
        end
    end

    // Write pointer, its gray copy and the write-side flags from the updated pointer.
    always_ff @(posedge WCLOCK or negedge RESET_W) begin
        if (!RESET_W) begin
            wptr   <= '0;
            wgray  <= '0;
            WCOUNT <= '0;
            FULL   <= 1'b0;
            AFULL  <= (AFULL_LVL == '0);
            WOVF   <= 1'b0;
        end else begin
            wptr   <= wptr_next;
            wgray  <= bin2gray(wptr_next);
            WCOUNT <= wcount_next;
            FULL   <= (wcount_next == DEPTH_LVL);
            AFULL  <= (wcount_next >= AFULL_LVL);
            if (WE && FULL) begin
                WOVF <= 1'b1;
            end
        end
    end

    // Bring the read gray pointer into the write domain.
    always_ff @(posedge WCLOCK or negedge RESET_W) begin
        if (!RESET_W) begin
            rgray_sync <= '0;
        end else begin
            rgray_sync <= {rgray_sync[SYNC_STAGES-2:0], rgray};
        end
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic                               r_ok;
    logic [AWIDTH:0]                    rptr;
    logic [AWIDTH:0]                    rptr_next;
    logic [AWIDTH:0]                    wptr_sync;
    logic [AWIDTH:0]                    rcount_next;
    logic [SYNC_STAGES-1:0][AWIDTH:0]   wgray_sync;

    assign r_ok        = RE & ~EMPTY;
    assign rptr_next   = rptr + {{AWIDTH{1'b0}}, r_ok};
    assign wptr_sync   = gray2bin(wgray_sync[SYNC_STAGES-1]);
    assign rcount_next = wptr_sync - rptr_next;

    // Read RAM port with output register; data holds when no read is taken.
    always_ff @(posedge RCLOCK or negedge RESET_R) begin
        if (!RESET_R) begin
            RDATA <= '0;
        end else if (r_ok) begin
            RDATA <= mem[rptr[AWIDTH-1:0]];
        end
    end

    // Read pointer, its gray copy and the read-side flags from the updated pointer.
    always_ff @(posedge RCLOCK or negedge RESET_R) begin
        if (!RESET_R) begin
            rptr   <= '0;
            rgray  <= '0;
            RDVAL  <= 1'b0;
            RCOUNT <= '0;
            EMPTY  <= 1'b1;
            AEMPTY <= 1'b1;
            RUDF   <= 1'b0;
        end else begin
            rptr   <= rptr_next;
            rgray  <= bin2gray(rptr_next);
            RDVAL  <= r_ok;
            RCOUNT <= rcount_next;
            EMPTY  <= (rcount_next == '0);
            AEMPTY <= (rcount_next <= AEMPTY_LVL);
            if (RE && EMPTY) begin
                RUDF <= 1'b1;
            end
        end
    end

    // Bring the write gray pointer into the read domain.
    always_ff @(posedge RCLOCK or negedge RESET_R) begin
        if (!RESET_R) begin
            wgray_sync <= '0;
        end else begin
            wgray_sync <= {wgray_sync[SYNC_STAGES-2:0], wgray};
        end
    end

endmodule

// File: tb/tb_aibfifo_param.sv
// tb_aibfifo_param: directed fill/drain vectors, overflow/underflow and joint
// reset sequences, and a randomized multi-ratio stream against a queue model.
`timescale 1ns/100ps
module tb_aibfifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;
    localparam int SS    = 2;

    // ---------------- clock / reset ----------------
    logic          RCLOCK  = 1'b0;
    logic          WCLOCK  = 1'b0;
    logic          RESET_R = 1'b0;
    logic          RESET_W = 1'b0;
    logic [DW-1:0] WDATA   = '0;
    logic          WE      = 1'b0;
    logic          RE      = 1'b0;
    logic [DW-1:0] RDATA;
    logic          RDVAL, FULL, AFULL, WOVF, EMPTY, AEMPTY, RUDF;
    logic [AW:0]   WCOUNT, RCOUNT;

    real w_half = 5.0;
    real r_half = 4.0;

    always #(w_half) WCLOCK = ~WCLOCK;
    always #(r_half) RCLOCK = ~RCLOCK;

    aibfifo_param #(
        .DWIDTH(DW), .AWIDTH(AW), .AFULL_TH(AFT), .AEMPTY_TH(AET), .SYNC_STAGES(SS)
    ) dut (
        .RCLOCK(RCLOCK), .RESET_R(RESET_R), .WCLOCK(WCLOCK), .RESET_W(RESET_W),
        .WDATA(WDATA), .WE(WE), .RE(RE), .RDATA(RDATA), .RDVAL(RDVAL),
        .FULL(FULL), .AFULL(AFULL), .WCOUNT(WCOUNT), .WOVF(WOVF),
        .EMPTY(EMPTY), .AEMPTY(AEMPTY), .RCOUNT(RCOUNT), .RUDF(RUDF)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_read;
        logic [DW-1:0] data;
        logic [AW:0]   cnt;
        bit          flag;
        bit          aflag;
    } vec_t;

    vec_t vecs[2*DEPTH];

    // ---------------- driver tasks ----------------
    // Both cycle tasks start and end 1 ns after an active edge of their clock.
    task automatic w_cycle(input logic we, input logic [DW-1:0] d);
        WE    = we;
        WDATA = d;
        @(posedge WCLOCK);
        #1;
        WE = 1'b0;
    endtask

    task automatic r_cycle(input logic re);
        RE = re;
        @(posedge RCLOCK);
        #1;
        RE = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        if (!v.is_read) begin
            w_cycle(1'b1, v.data);
            check("fill_wcount", WCOUNT, v.cnt);
            check("fill_full",   FULL,   v.flag);
            check("fill_afull",  AFULL,  v.aflag);
            check("fill_wovf",   WOVF,   0);
        end else begin
            r_cycle(1'b1);
            check("drain_rdval",  RDVAL,  1);
            check("drain_rdata",  RDATA,  v.data);
            check("drain_rcount", RCOUNT, v.cnt);
            check("drain_empty",  EMPTY,  v.flag);
            check("drain_aempty", AEMPTY, v.aflag);
        end
    endtask

    // Random writer: pushes accepted words into the model queue.
    task automatic writer(input int n, input int pct);
        int            pushed = 0;
        int            cyc    = 0;
        logic          acc;
        logic [DW-1:0] wd;
        @(posedge WCLOCK);
        #1;
        while (pushed < n && cyc < 20000) begin
            wd    = DW'($urandom_range(255));
            WE    = ($urandom_range(99) < pct);
            WDATA = wd;
            acc   = WE && !FULL;
            if (acc) check("wr_model_room", exp_q.size() < DEPTH, 1);
            @(posedge WCLOCK);
            #1;
            if (acc) begin
                exp_q.push_back(wd);
                pushed++;
            end
            check("wr_wcount_bound", (int'(WCOUNT) >= exp_q.size()) && (int'(WCOUNT) <= DEPTH), 1);
            cyc++;
        end
        WE = 1'b0;
        check("wr_done", pushed, n);
    endtask

    // Random reader: every accepted read must return the oldest model word.
    task automatic reader(input int n, input int pct);
        int            popped = 0;
        int            cyc    = 0;
        logic          acc;
        logic [DW-1:0] e;
        @(posedge RCLOCK);
        #1;
        while (popped < n && cyc < 20000) begin
            RE  = ($urandom_range(99) < pct);
            acc = RE && !EMPTY;
            @(posedge RCLOCK);
            #1;
            if (acc) begin
                check("rd_rdval", RDVAL, 1);
                check("rd_model_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rd_data", RDATA, e);
                    popped++;
                end
            end else begin
                check("rd_idle_rdval", RDVAL, 0);
            end
            check("rd_rcount_bound", int'(RCOUNT) <= exp_q.size(), 1);
            cyc++;
        end
        RE = 1'b0;
        check("rd_done", popped, n);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;

        for (int i = 0; i < DEPTH; i++) begin
            vecs[i].is_read = 1'b0;
            vecs[i].data    = DW'(i);
            vecs[i].cnt     = (AW+1)'(i + 1);
            vecs[i].flag    = (i + 1 == DEPTH);
            vecs[i].aflag   = (i + 1 >= AFT);
        end
        for (int k = 0; k < DEPTH; k++) begin
            vecs[DEPTH+k].is_read = 1'b1;
            vecs[DEPTH+k].data    = DW'(k);
            vecs[DEPTH+k].cnt     = (AW+1)'(DEPTH - 1 - k);
            vecs[DEPTH+k].flag    = (k == DEPTH - 1);
            vecs[DEPTH+k].aflag   = (DEPTH - 1 - k <= AET);
        end

        // Reset values while both resets are held.
        #20;
        check("rst_empty",  EMPTY,  1);
        check("rst_aempty", AEMPTY, 1);
        check("rst_rdval",  RDVAL,  0);
        check("rst_rdata",  RDATA,  0);
        check("rst_rcount", RCOUNT, 0);
        check("rst_rudf",   RUDF,   0);
        check("rst_full",   FULL,   0);
        check("rst_afull",  AFULL,  0);
        check("rst_wcount", WCOUNT, 0);
        check("rst_wovf",   WOVF,   0);
        #23;
        RESET_W = 1'b1;
        RESET_R = 1'b1;

        // Basic fill from the table.
        @(posedge WCLOCK);
        #1;
        for (int i = 0; i < DEPTH; i++) apply_vec(vecs[i]);

        // Overflow: WE held while FULL.
        for (int i = 0; i < 3; i++) begin
            w_cycle(1'b1, 8'hEE);
            check("ovf_wcount", WCOUNT, DEPTH);
            check("ovf_full",   FULL,   1);
            check("ovf_wovf",   WOVF,   1);
        end

        // Let the write pointer reach the read side.
        repeat (6) @(posedge RCLOCK);
        #1;
        check("sync_rcount", RCOUNT, DEPTH);
        check("sync_empty",  EMPTY,  0);
        check("sync_aempty", AEMPTY, 0);

        // Ordered drain from the table.
        for (int i = DEPTH; i < 2*DEPTH; i++) apply_vec(vecs[i]);

        // Underflow: read pulse on empty FIFO.
        r_cycle(1'b1);
        check("udf_rdval", RDVAL, 0);
        check("udf_rdata", RDATA, 8'h0F);
        check("udf_rudf",  RUDF,  1);
        check("udf_empty", EMPTY, 1);
        r_cycle(1'b0);
        check("udf_sticky", RUDF, 1);

        // Write side sees the drain after the synchroniser delay.
        repeat (8) @(posedge WCLOCK);
        #1;
        check("drain_w_full",   FULL,   0);
        check("drain_w_afull",  AFULL,  0);
        check("drain_w_wcount", WCOUNT, 0);
        check("wovf_sticky",    WOVF,   1);

        // Randomized stream at three clock ratios, 1000 words total.
        exp_q.delete();
        w_half = 5.0; r_half = 4.0;
        fork
            writer(334, 60);
            reader(334, 50);
        join
        w_half = 3.0; r_half = 7.0;
        fork
            writer(333, 70);
            reader(333, 80);
        join
        w_half = 6.0; r_half = 3.5;
        fork
            writer(333, 50);
            reader(333, 40);
        join
        check("stream_model_empty", exp_q.size(), 0);

        // Joint reset with 9 entries held.
        w_half = 5.0; r_half = 4.0;
        @(posedge WCLOCK);
        #1;
        for (int i = 0; i < 9; i++) w_cycle(1'b1, DW'(8'h30 + i));
        repeat (6) @(posedge RCLOCK);
        #1;
        check("held_rcount", RCOUNT, 9);
        #2;
        RESET_W = 1'b0;
        RESET_R = 1'b0;
        #40;
        RESET_W = 1'b1;
        RESET_R = 1'b1;
        @(posedge WCLOCK);
        #1;
        check("jrst_full",   FULL,   0);
        check("jrst_afull",  AFULL,  0);
        check("jrst_wcount", WCOUNT, 0);
        check("jrst_wovf",   WOVF,   0);
        @(posedge RCLOCK);
        #1;
        check("jrst_empty",  EMPTY,  1);
        check("jrst_aempty", AEMPTY, 1);
        check("jrst_rcount", RCOUNT, 0);
        check("jrst_rudf",   RUDF,   0);
        check("jrst_rdval",  RDVAL,  0);

        @(posedge WCLOCK);
        #1;
        w_cycle(1'b1, 8'hA5);
        t = 0;
        @(posedge RCLOCK);
        #1;
        while (EMPTY && t < 20) begin
            @(posedge RCLOCK);
            #1;
            t++;
        end
        check("a5_empty_fall", EMPTY, 0);
        r_cycle(1'b1);
        check("a5_rdval", RDVAL, 1);
        check("a5_rdata", RDATA, 8'hA5);
        check("a5_empty", EMPTY, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aibfifo_param.md
Name: aibfifo_param

Overview:
Parametrised dual-clock FIFO, the successor to the fixed 8-bit × 32-entry AI-board bfifo. It generalises data width and depth and uses an inferred dual-port RAM instead of a hand-instantiated RAM64x18. It adds protection against overflow and underflow, sticky error flags, almost-full and almost-empty thresholds, and fill-level counts in both domains. It sits between the AI acquisition logic (WCLOCK) and the 125 MHz processing and communication logic (RCLOCK).

Parameters:
DWIDTH, 8, data width in bits (1..64).
AWIDTH, 6, address width; depth is 2^AWIDTH entries (2..10).
AFULL_TH, 56, WCOUNT level at or above which AFULL asserts (1..2^AWIDTH-1).
AEMPTY_TH, 4, RCOUNT level at or below which AEMPTY asserts (0..2^AWIDTH-1).
SYNC_STAGES, 2, number of flops in each gray-pointer synchroniser (2..4).

Ports:
RCLOCK  input  1  read clock.
RESET_R  input  1  read-domain reset; asynchronous, active-low.
WCLOCK  input  1  write clock.
RESET_W  input  1  write-domain reset; asynchronous, active-low.
WDATA  input  DWIDTH  write data.
WE  input  1  write request.
RE  input  1  read request.
RDATA  output  DWIDTH  read data; valid while RDVAL=1.
RDVAL  output  1  read data valid; asserts one cycle after an accepted read.
FULL  output  1  full flag (WCLOCK domain).
AFULL  output  1  almost-full flag (WCLOCK domain).
WCOUNT  output  AWIDTH+1  fill level seen by the write side.
WOVF  output  1  sticky overflow flag: a write was attempted while FULL.
EMPTY  output  1  empty flag (RCLOCK domain).
AEMPTY  output  1  almost-empty flag (RCLOCK domain).
RCOUNT  output  AWIDTH+1  fill level seen by the read side.
RUDF  output  1  sticky underflow flag: a read was attempted while EMPTY.

Behaviour:
- Pointers: wptr and rptr are AWIDTH+1-bit binary counters that wrap naturally. The RAM address is ptr[AWIDTH-1:0]. The MSB distinguishes full from empty.
- Write acceptance: a write is accepted when WE=1 and FULL=0. The accepted word is written to mem[wptr] and wptr increments. WE=1 with FULL=1 is dropped: no pointer change, no RAM write, and WOVF is set.
- Read acceptance: a read is accepted when RE=1 and EMPTY=0. RDATA is registered from mem[rptr] on that edge, rptr increments, and RDVAL=1 on the next cycle. RE=1 with EMPTY=1 is dropped: RDVAL=0, RDATA holds its value, and RUDF is set.
- Read latency: exactly 1 RCLOCK cycle.
- Clock-domain crossing: the gray code of the next pointer is registered in its source domain, then passes through SYNC_STAGES flops in the destination domain, then through a gray-to-binary conversion. No binary pointer crosses domains.
- Count arithmetic: RCOUNT = wptr_sync − rptr and WCOUNT = wptr − rptr_sync, both modulo 2^(AWIDTH+1).
- Flag timing: all flags are registered and computed from the post-update pointer.
  - FULL asserts on the same WCLOCK edge that accepts the 2^AWIDTH-th entry, so a continuous WE can never overflow.
  - EMPTY asserts on the edge that accepts the last read.
- Flag pessimism: FULL and AFULL deassert late after reads, and EMPTY and AEMPTY deassert late after writes. The delay is SYNC_STAGES+1 destination-clock edges after the source pointer register updates, with +1 cycle of synchroniser uncertainty. Flags are never optimistic.
- Thresholds: AFULL = (WCOUNT ≥ AFULL_TH). AEMPTY = (RCOUNT ≤ AEMPTY_TH).
- Simultaneous read and write in the same cycle, including at full or empty: both are legal and both are evaluated against the current registered flags.
- Read-domain reset values: EMPTY=1, AEMPTY=1, RDVAL=0, RDATA=0, RCOUNT=0, RUDF=0, and rptr and its synchronisers are 0.
- Write-domain reset values: FULL=0, AFULL=0 (or 1 if AFULL_TH=0 is ever allowed), WCOUNT=0, WOVF=0, and wptr and its synchronisers are 0.
- Sticky flags: WOVF and RUDF clear only on their own domain's reset.
- Reset mid-operation: the two resets must be asserted together, for a minimum overlap of SYNC_STAGES+1 cycles of the slower clock. After both are released the FIFO is empty and contents are discarded. Asserting only one reset is illegal; flags are undefined until both domains are reset.
- RAM: inferred simple dual-port memory, written on WCLOCK and read on RCLOCK. It has no reset and no read-during-write requirement, because the flags prevent address collisions on valid data.

Test Plan:
- Basic fill (DWIDTH=8, AWIDTH=4, AFULL_TH=14, AEMPTY_TH=2; WCLOCK=100 MHz, RCLOCK=125 MHz): write 0x00..0x0F continuously → FULL rises on the edge that accepts 0x0F, AFULL is already 1 at WCOUNT=14, WOVF=0.
- Ordered drain: read 16 times → RDATA equals 0x00..0x0F in order, each with RDVAL=1 one cycle after its RE, and EMPTY=1 after the 16th read.
- Overflow protection: hold WE=1 for 3 cycles with FULL=1 → wptr unchanged and WOVF=1 sticky; the later drain still returns 0x00..0x0F with no corruption.
- Underflow protection: pulse RE on an empty FIFO → RDVAL=0, RDATA holds its value, RUDF=1.
- Wrap-around: stream 1000 words with random WE/RE and ratioed clocks (including RCLOCK faster and slower than WCLOCK) → read data matches a scoreboard, RCOUNT ≤ 16, and EMPTY never falls before the data is written.
- Joint reset mid-stream with 9 entries held: assert RESET_W and RESET_R together → EMPTY=1, RCOUNT=WCOUNT=0 and FULL=0 after release; a subsequent write of 0xA5 is read back as 0xA5.
